uarc_rx_arbiter: RTL and testbench

Shares the core0 receiver bus between several character-producing peripherals (PS/2 keyboard, UART, debug injector). Each source gets a small FIFO that absorbs one-cycle character pulses. A round-robin scheduler offers one buffered character at a time on the core's `receiver_sends` / `receiver_send_acks` handshake, and drives `receiver_datas` with the character tagged by its source index. It replaces the single-character overwrite buffer between `ps2_ascii` and `core0`.

---
 rtl/uarc_rx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uarc_rx_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uarc_rx_arbiter.sv
// Round-robin arbiter feeding the core receiver handshake from several character sources.
// Each source has a small FIFO. One buffered character at a time is offered, tagged with its source index.
module uarc_rx_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int SOURCES    = 2,
  parameter int FIFO_MAG   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SOURCES-1:0]    src_valid,
  input  logic [SOURCES*8-1:0]  src_char,
  output logic [SOURCES-1:0]    src_overflow,
  output logic                  send,
  input  logic                  send_ack,
  output logic [WORD_WIDTH-1:0] data,
  output logic                  pending
);

  localparam int DEPTH = 1 << FIFO_MAG;
  localparam int IDX_W = (SOURCES > 1) ? $clog2(SOURCES) : 1;
  localparam logic [FIFO_MAG:0] MSB_ONLY = {1'b1, {FIFO_MAG{1'b0}}};

  typedef enum logic {IDLE, OFFER} state_t;

  state_t state, state_next;

  logic [7:0]        mem    [SOURCES][DEPTH];
  logic [FIFO_MAG:0] wr_ptr [SOURCES];
  logic [FIFO_MAG:0] rd_ptr [SOURCES];
  logic [7:0]        head   [SOURCES];

  logic [SOURCES-1:0]    empty;
  logic [SOURCES-1:0]    full;
  logic [SOURCES-1:0]    pop;
  logic [SOURCES-1:0]    wr_en;
  logic [IDX_W-1:0]      last_grant;
  logic [IDX_W-1:0]      grant;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      cand;
  logic                  pick_valid;
  logic                  load_offer;
  logic                  take_ack;
  logic [WORD_WIDTH-1:0] offer_word;

  // A pop frees a slot in the same edge, so a write into a full FIFO that is being popped is still accepted.
  always_comb begin
    empty = '0;
    full  = '0;
    pop   = '0;
    wr_en = '0;
    for (int i = 0; i < SOURCES; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = ((wr_ptr[i] ^ rd_ptr[i]) == MSB_ONLY);
      pop[i]   = take_ack && (grant == IDX_W'(i));
      wr_en[i] = src_valid[i] && (!full[i] || pop[i]);
      head[i]  = mem[i][rd_ptr[i][FIFO_MAG-1:0]];
    end
  end

  // The search runs downward so the candidate closest after last_grant is the one that sticks.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = SOURCES - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(last_grant) + 1 + k) % SOURCES);
      if (!empty[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    offer_word       = '0;
    offer_word[15:0] = {8'(pick_idx), head[pick_idx]};
  end

  always_comb begin
    state_next = state;
    load_offer = 1'b0;
    take_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          load_offer = 1'b1;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (send_ack) begin
          take_ack   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Last-grant starts at the top index so source 0 is served first after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      send       <= 1'b0;
      data       <= '0;
      grant      <= '0;
      last_grant <= IDX_W'(SOURCES - 1);
    end else begin
      if (load_offer) begin
        send  <= 1'b1;
        grant <= pick_idx;
        data  <= offer_word;
      end
      if (take_ack) begin
        send       <= 1'b0;
        last_grant <= grant;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_overflow <= '0;
      for (int i = 0; i < SOURCES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SOURCES; i++) begin
        src_overflow[i] <= src_valid[i] && full[i] && !pop[i];
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])   rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SOURCES; i++) begin
      if (wr_en[i]) mem[i][wr_ptr[i][FIFO_MAG-1:0]] <= src_char[i*8 +: 8];
    end
  end

  assign pending = send | ~&empty;

endmodule

// File: tb/tb_uarc_rx_arbiter.sv
// Bench for uarc_rx_arbiter: table of per-cycle vectors with hand-computed outputs,
// followed by a hand-written asynchronous-reset-during-offer sequence.
module tb_uarc_rx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  src_valid;
  logic [15:0] src_char;
  logic [1:0]  src_overflow;
  logic        send;
  logic        send_ack;
  logic [31:0] data;
  logic        pending;

  int errors = 0;
  int checks = 0;

  uarc_rx_arbiter #(.WORD_WIDTH(32), .SOURCES(2), .FIFO_MAG(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .src_valid    (src_valid),
    .src_char     (src_char),
    .src_overflow (src_overflow),
    .send         (send),
    .send_ack     (send_ack),
    .data         (data),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [7:0]  c0;
    logic [7:0]  c1;
    logic        ack;
    logic        e_send;
    logic [31:0] e_data;
    logic        e_pend;
    logic [1:0]  e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst, input logic [1:0] valid, input logic [7:0] c0,
                         input logic [7:0] c1, input logic ack, input logic e_send,
                         input logic [31:0] e_data, input logic e_pend, input logic [1:0] e_ovf);
    vec_t v;
    v.rst = rst; v.valid = valid; v.c0 = c0; v.c1 = c1; v.ack = ack;
    v.e_send = e_send; v.e_data = e_data; v.e_pend = e_pend; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the edge; registered outputs are sampled 1 unit later.
  task automatic apply_stimulus(input vec_t v);
    @(posedge clk);
    #1;
    reset     = v.rst;
    src_valid = v.valid;
    src_char  = {v.c1, v.c0};
    send_ack  = v.ack;
    #1;
  endtask

  task automatic add_reset;
    add_vec(1, 2'b00, 8'h00, 8'h00, 0, 0, 32'h0, 0, 2'b00);
  endtask

  initial begin
    reset     = 1'b1;
    src_valid = '0;
    src_char  = '0;
    send_ack  = 1'b0;

    // Single character with ack tied high
    add_reset();
    add_vec(0, 2'b01, 8'h41, 8'h00, 1, 0, 32'h0,  0, 2'b00);
    add_vec(0, 2'b00, 8'h00, 8'h00, 1, 0, 32'h0,  1, 2'b00);
    add_vec(0, 2'b00, 8'h00, 8'h00, 1, 1, 32'h41, 1, 2'b00);
    add_vec(0, 2'b00, 8'h00, 8'h00, 1, 0, 32'h41, 0, 2'b00);
    add_vec(0, 2'b00, 8'h00, 8'h00, 1, 0, 32'h41, 0, 2'b00);

    // Round-robin across two sources
    add_reset();
    add_vec(0, 2'b11, "a", "x", 1, 0, 32'h0,    0, 2'b00);
    add_vec(0, 2'b11, "b", "y", 1, 0, 32'h0,    1, 2'b00);
    add_vec(0, 2'b00, 0,   0,   1, 1, 32'h0061, 1, 2'b00);
    add_vec(0, 2'b00, 0,   0,   1, 0, 32'h0061, 1, 2'b00);
    add_vec(0, 2'b00, 0,   0,   1, 1, 32'h0178, 1, 2'b00);
    add_vec(0, 2'b00, 0,   0,   1, 0, 32'h0178, 1, 2'b00);
    add_vec(0, 2'b00, 0,   0,   1, 1, 32'h0062, 1, 2'b00);
    add_vec(0, 2'b00, 0,   0,   1, 0, 32'h0062, 1, 2'b00);
    add_vec(0, 2'b00, 0,   0,   1, 1, 32'h0179, 1, 2'b00);
    add_vec(0, 2'b00, 0,   0,   1, 0, 32'h0179, 0, 2'b00);

    // Overflow on source 1, then a 10-cycle stall and release
    add_reset();
    add_vec(0, 2'b10, 0, 8'h10, 0, 0, 32'h0,    0, 2'b00);
    add_vec(0, 2'b10, 0, 8'h11, 0, 0, 32'h0,    1, 2'b00);
    add_vec(0, 2'b10, 0, 8'h12, 0, 1, 32'h0110, 1, 2'b00);
    add_vec(0, 2'b10, 0, 8'h13, 0, 1, 32'h0110, 1, 2'b00);
    add_vec(0, 2'b10, 0, 8'h14, 0, 1, 32'h0110, 1, 2'b00);
    add_vec(0, 2'b00, 0, 0,     0, 1, 32'h0110, 1, 2'b10);
    for (int k = 0; k < 6; k++) add_vec(0, 2'b00, 0, 0, 0, 1, 32'h0110, 1, 2'b00);
    add_vec(0, 2'b00, 0, 0, 1, 1, 32'h0110, 1, 2'b00);
    add_vec(0, 2'b00, 0, 0, 1, 0, 32'h0110, 1, 2'b00);
    add_vec(0, 2'b00, 0, 0, 1, 1, 32'h0111, 1, 2'b00);
    add_vec(0, 2'b00, 0, 0, 1, 0, 32'h0111, 1, 2'b00);
    add_vec(0, 2'b00, 0, 0, 1, 1, 32'h0112, 1, 2'b00);
    add_vec(0, 2'b00, 0, 0, 1, 0, 32'h0112, 1, 2'b00);
    add_vec(0, 2'b00, 0, 0, 1, 1, 32'h0113, 1, 2'b00);
    add_vec(0, 2'b00, 0, 0, 1, 0, 32'h0113, 0, 2'b00);
    add_vec(0, 2'b00, 0, 0, 1, 0, 32'h0113, 0, 2'b00);

    // Full FIFO with write and pop in the same cycle
    add_reset();
    add_vec(0, 2'b01, 8'h20, 0, 0, 0, 32'h0,    0, 2'b00);
    add_vec(0, 2'b01, 8'h21, 0, 0, 0, 32'h0,    1, 2'b00);
    add_vec(0, 2'b01, 8'h22, 0, 0, 1, 32'h0020, 1, 2'b00);
    add_vec(0, 2'b01, 8'h23, 0, 0, 1, 32'h0020, 1, 2'b00);
    add_vec(0, 2'b01, 8'h5A, 0, 1, 1, 32'h0020, 1, 2'b00);
    add_vec(0, 2'b00, 0,     0, 1, 0, 32'h0020, 1, 2'b00);
    add_vec(0, 2'b00, 0,     0, 1, 1, 32'h0021, 1, 2'b00);
    add_vec(0, 2'b00, 0,     0, 1, 0, 32'h0021, 1, 2'b00);
    add_vec(0, 2'b00, 0,     0, 1, 1, 32'h0022, 1, 2'b00);
    add_vec(0, 2'b00, 0,     0, 1, 0, 32'h0022, 1, 2'b00);
    add_vec(0, 2'b00, 0,     0, 1, 1, 32'h0023, 1, 2'b00);
    add_vec(0, 2'b00, 0,     0, 1, 0, 32'h0023, 1, 2'b00);
    add_vec(0, 2'b00, 0,     0, 1, 1, 32'h005A, 1, 2'b00);
    add_vec(0, 2'b00, 0,     0, 1, 0, 32'h005A, 0, 2'b00);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d send", i),     32'(send),         32'(vecs[i].e_send));
      check_output($sformatf("vec%0d data", i),     data,              vecs[i].e_data);
      check_output($sformatf("vec%0d pending", i),  32'(pending),      32'(vecs[i].e_pend));
      check_output($sformatf("vec%0d overflow", i), 32'(src_overflow), 32'(vecs[i].e_ovf));
    end

    // Asynchronous reset between edges while an offer is outstanding
    @(posedge clk); #1;
    reset = 1'b1; src_valid = '0; send_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; src_valid = 2'b10; src_char = {8'h33, 8'h00};
    @(posedge clk); #1;
    src_valid = '0;
    @(posedge clk); #1;
    check_output("async pre send", 32'(send), 32'd1);
    check_output("async pre data", data, 32'h0133);
    #3;
    reset = 1'b1;
    #1;
    check_output("async send", 32'(send), 32'd0);
    check_output("async data", data, 32'h0);
    check_output("async pending", 32'(pending), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; send_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2;
      check_output($sformatf("post-reset send c%0d", k), 32'(send), 32'd0);
      check_output($sformatf("post-reset pending c%0d", k), 32'(pending), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
